// File: rtl/seq_sub_serial_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface seq_sub_serial_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             borrow;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, borrow, overflow, zero
    );

    modport slave (
        input  in_valid, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, borrow, overflow, zero
    );
endinterface

// File: rtl/seq_sub_serial.sv
// Bit-serial subtractor: result = operand_a - operand_b, LSB first, one bit per clock,
// with unsigned borrow, signed overflow and zero flags.
module seq_sub_serial #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    seq_sub_serial_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] a_sh, a_sh_d, b_sh, b_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             br, br_d;
    logic             a_msb, a_msb_d, b_msb, b_msb_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;

    // One full-subtractor cell applied to the current LSBs.
    assign d_bit   = a_sh[0] ^ b_sh[0] ^ br;
    assign br_nxt  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign res_nxt = {d_bit, result_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state;
        a_sh_d      = a_sh;
        b_sh_d      = b_sh;
        result_d    = result_q;
        cnt_d       = cnt;
        br_d        = br;
        a_msb_d     = a_msb;
        b_msb_d     = b_msb;
        borrow_d    = borrow_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;

        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_sh_d  = bus.operand_a;
                    b_sh_d  = bus.operand_b;
                    a_msb_d = bus.operand_a[WIDTH-1];
                    b_msb_d = bus.operand_b[WIDTH-1];
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_sh_d   = {1'b0, a_sh[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh[WIDTH-1:1]};
                result_d = res_nxt;
                br_d     = br_nxt;
                cnt_d    = cnt + CNT_W'(1);
                // Flags are resolved on the last bit so they appear together with out_valid.
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    borrow_d   = br_nxt;
                    overflow_d = (a_msb != b_msb) && (d_bit != a_msb);
                    zero_d     = (res_nxt == '0);
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            result_q    <= '0;
            cnt         <= '0;
            br          <= 1'b0;
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            borrow_q    <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state       <= state_d;
            a_sh        <= a_sh_d;
            b_sh        <= b_sh_d;
            result_q    <= result_d;
            cnt         <= cnt_d;
            br          <= br_d;
            a_msb       <= a_msb_d;
            b_msb       <= b_msb_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            borrow_q    <= borrow_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.borrow    = borrow_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_seq_sub_serial.sv
// Self-checking bench for seq_sub_serial at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_seq_sub_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_sub_serial_if #(.WIDTH(4)) bus4 ();
    seq_sub_serial_if #(.WIDTH(8)) bus8 ();

    seq_sub_serial #(.WIDTH(4), .CNT_W(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    seq_sub_serial #(.WIDTH(8), .CNT_W(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {zero, overflow, borrow, result} from plain integer arithmetic.
    function automatic logic [34:0] model(input int w, input int unsigned a, input int unsigned b);
        int unsigned msk = (32'd1 << w) - 32'd1;
        int unsigned r   = (a - b) & msk;
        int sa = ((a >> (w - 1)) != 0) ? int'(a) - (1 << w) : int'(a);
        int sb = ((b >> (w - 1)) != 0) ? int'(b) - (1 << w) : int'(b);
        int d  = sa - sb;
        logic ov = (d < -(1 << (w - 1))) || (d > (1 << (w - 1)) - 1);
        return {(r == 0), ov, (a < b), r};
    endfunction

    // Per-cycle model of the WIDTH=4 instance.
    logic        m_idle = 1'b1;
    logic        m_valid = 1'b0;
    int          m_left = 0;
    logic [34:0] m_next = '0;
    logic [34:0] shown = '0;
    logic        b2b = 1'b0;
    int          last_acc = -1;

    always @(negedge clk) begin
        if (rst) begin
            m_idle  = 1'b1;
            m_valid = 1'b0;
            m_left  = 0;
            shown   = '0;
            chk("rst in_ready", 35'(bus4.in_ready), 35'd1);
            chk("rst out_valid", 35'(bus4.out_valid), 35'd0);
            chk("rst outputs", {bus4.zero, bus4.overflow, bus4.borrow, 28'd0, bus4.result}, 35'd0);
        end else begin
            chk("in_ready", 35'(bus4.in_ready), 35'(m_idle));
            chk("out_valid", 35'(bus4.out_valid), 35'(m_valid));
            chk("flags", 35'({bus4.zero, bus4.overflow, bus4.borrow}), 35'(shown[34:32]));
            if (m_idle || m_valid)
                chk("result", 35'(bus4.result), 35'(shown[3:0]));
            if (!b2b) last_acc = -1;
            if (m_idle && bus4.in_valid) begin
                m_next = model(4, 32'(bus4.operand_a), 32'(bus4.operand_b));
                m_idle = 1'b0;
                m_left = 4;
                if (b2b && last_acc >= 0) chk("w4 accept spacing", 35'(cyc + 1 - last_acc), 35'd6);
                last_acc = cyc + 1;
            end else if (!m_idle && !m_valid) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    shown   = m_next;
                end
            end else if (m_valid && bus4.out_ready) begin
                m_valid = 1'b0;
                m_idle  = 1'b1;
            end
        end
    end

    // Scoreboard for the WIDTH=8 instance.
    logic [34:0] q8[$];
    int          last8 = -1;
    int          n8_acc = 0;
    int          n8_out = 0;

    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            last8 = -1;
        end else begin
            if (bus8.out_valid && bus8.out_ready) begin
                n8_out++;
                if (q8.size() == 0) chk("w8 unexpected out_valid", 35'd1, 35'd0);
                else chk("w8 result", {bus8.zero, bus8.overflow, bus8.borrow, 24'd0, bus8.result}, q8.pop_front());
            end
            if (bus8.in_valid && bus8.in_ready) begin
                q8.push_back(model(8, 32'(bus8.operand_a), 32'(bus8.operand_b)));
                if (last8 >= 0) chk("w8 accept spacing", 35'(cyc + 1 - last8), 35'd10);
                last8 = cyc + 1;
                n8_acc++;
            end
        end
    end

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] er,
                         input logic ebr, input logic eov, input logic ez);
        int acc;
        bit seen = 0;
        @(posedge clk); #1;
        bus4.in_valid  = 1'b1;
        bus4.operand_a = a;
        bus4.operand_b = b;
        acc = cyc + 1;
        @(posedge clk); #1;
        bus4.in_valid  = 1'b0;
        bus4.operand_a = 4'($urandom_range(0, 15));
        bus4.operand_b = 4'($urandom_range(0, 15));
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus4.out_valid) seen = 1;
        end
        if (!seen) begin
            chk("out_valid timeout", 35'd0, 35'd1);
        end else begin
            chk("latency", 35'(cyc - acc), 35'd4);
            chk("lit result", 35'(bus4.result), 35'(er));
            chk("lit flags", 35'({bus4.borrow, bus4.overflow, bus4.zero}), 35'({ebr, eov, ez}));
        end
    endtask

    initial begin
        bus4.in_valid = 1'b0; bus4.operand_a = '0; bus4.operand_b = '0; bus4.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.operand_a = '0; bus8.operand_b = '0; bus8.out_ready = 1'b1;

        chk("model 5-3", model(4, 5, 3),  {1'b0, 1'b0, 1'b0, 32'd2});
        chk("model 3-5", model(4, 3, 5),  {1'b0, 1'b0, 1'b1, 32'd14});
        chk("model 8-1", model(4, 8, 1),  {1'b0, 1'b1, 1'b0, 32'd7});
        chk("model 7-F", model(4, 7, 15), {1'b0, 1'b1, 1'b1, 32'd8});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        do_op(4'h5, 4'h3, 4'h2, 1'b0, 1'b0, 1'b0);
        do_op(4'h3, 4'h5, 4'hE, 1'b1, 1'b0, 1'b0);
        do_op(4'h7, 4'h7, 4'h0, 1'b0, 1'b0, 1'b1);
        do_op(4'h8, 4'h1, 4'h7, 1'b0, 1'b1, 1'b0);
        do_op(4'h7, 4'hF, 4'h8, 1'b1, 1'b1, 1'b0);

        // Consumer stalls for 10 cycles while stray in_valid pulses arrive.
        @(posedge clk); #1 bus4.out_ready = 1'b0;
        do_op(4'h6, 4'h1, 4'h5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus4.in_valid  = ~bus4.in_valid;
            bus4.operand_a = 4'($urandom_range(0, 15));
            bus4.operand_b = 4'($urandom_range(0, 15));
            @(negedge clk);
            chk("hold out_valid", 35'(bus4.out_valid), 35'd1);
            chk("hold in_ready", 35'(bus4.in_ready), 35'd0);
            chk("hold result", 35'(bus4.result), 35'h5);
        end
        @(posedge clk); #1;
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Reset in the middle of the serial computation.
        #1;
        bus4.in_valid = 1'b1; bus4.operand_a = 4'h3; bus4.operand_b = 4'h1;
        @(posedge clk); #1 bus4.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post-rst in_ready", 35'(bus4.in_ready), 35'd1);
        chk("post-rst result", 35'(bus4.result), 35'd0);
        do_op(4'h9, 4'h4, 4'h5, 1'b0, 1'b1, 1'b0);

        // Back-to-back random traffic on the WIDTH=4 instance.
        @(posedge clk); #1;
        b2b = 1'b1;
        bus4.in_valid = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            bus4.operand_a = 4'($urandom_range(0, 15));
            bus4.operand_b = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        bus4.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 b2b = 1'b0;

        // Back-to-back random traffic on the WIDTH=8 instance.
        bus8.in_valid = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            bus8.operand_a = 8'($urandom_range(0, 255));
            bus8.operand_b = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        bus8.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("w8 all results returned", 35'(n8_out), 35'(n8_acc));
        chk("w8 enough accepts", 35'(n8_acc >= 999), 35'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
